// File: rtl/divider_result_checker.sv
// Independent checker for divider results: rebuilds quotient*divisor+remainder with
// a shift-add multiply and reports a per-transaction verdict plus saturating tallies.
module divider_result_checker #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [WIDTH-1:0]     quotient,
  input  logic [WIDTH-1:0]     remainder,
  input  logic                 div_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 pass,
  output logic [1:0]           fail_code,
  output logic [CNT_WIDTH-1:0] pass_count,
  output logic [CNT_WIDTH-1:0] fail_count
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]        BIT_LAST = CW'(WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, MULT, COMPARE, REPORT} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   dividend_reg;
  logic [WIDTH-1:0]   divisor_reg;
  logic [WIDTH-1:0]   quotient_reg;
  logic [WIDTH-1:0]   remainder_reg;
  logic               err_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CW-1:0]      cnt_reg;

  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH:0]   recon;
  logic [1:0]         code_next;

  assign addend = {{WIDTH{1'b0}}, divisor_reg} << cnt_reg;
  // One extra bit so quotient overflow shows up as a mismatch rather than wrapping.
  assign recon  = {1'b0, acc_reg} + {{(WIDTH+1){1'b0}}, remainder_reg};

  always_comb begin
    code_next = 2'b00;
    if (divisor_reg == '0)
      code_next = err_reg ? 2'b00 : 2'b01;
    else if (err_reg)
      code_next = 2'b01;
    else if (recon != {{(WIDTH+1){1'b0}}, dividend_reg})
      code_next = 2'b10;
    else if (remainder_reg >= divisor_reg)
      code_next = 2'b11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      err_reg       <= 1'b0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      pass          <= 1'b0;
      fail_code     <= 2'b00;
      pass_count    <= '0;
      fail_count    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            dividend_reg  <= dividend;
            divisor_reg   <= divisor;
            quotient_reg  <= quotient;
            remainder_reg <= remainder;
            err_reg       <= div_err;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            in_ready      <= 1'b0;
            state_reg     <= (divisor == '0) ? COMPARE : MULT;
          end else begin
            in_ready <= 1'b1;
          end
        end
        MULT: begin
          if (quotient_reg[cnt_reg])
            acc_reg <= acc_reg + addend;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == BIT_LAST)
            state_reg <= COMPARE;
        end
        COMPARE: begin
          pass      <= (code_next == 2'b00);
          fail_code <= code_next;
          if (code_next == 2'b00) begin
            if (pass_count != '1)
              pass_count <= pass_count + CNT_ONE;
          end else begin
            if (fail_count != '1)
              fail_count <= fail_count + CNT_ONE;
          end
          state_reg <= REPORT;
        end
        REPORT: begin
          // Verdict is presented one cycle after entry and held until consumed.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_result_checker.sv
// Directed bench for divider_result_checker (WIDTH=8, CNT_WIDTH=4) with a
// transaction-level model of the verdict rules and saturating counters.
module tb_divider_result_checker;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  dividend = '0, divisor = '0, quotient = '0, remainder = '0;
  logic          div_err = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          pass;
  logic [1:0]    fail_code;
  logic [CW-1:0] pass_count, fail_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Expectations for the transaction currently in flight.
  logic exp_valid = 1'b0;
  int   exp_code  = 0;
  int   m_pass    = 0;
  int   m_fail    = 0;

  divider_result_checker #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .quotient(quotient),
    .remainder(remainder), .div_err(div_err), .out_valid(out_valid),
    .out_ready(out_ready), .pass(pass), .fail_code(fail_code),
    .pass_count(pass_count), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Verdict rules evaluated with ordinary integer arithmetic.
  function automatic int model_code(input int dvd, input int dvs, input int q, input int r, input bit err);
    if (dvs == 0) return err ? 0 : 1;
    if (err) return 1;
    if (q * dvs + r != dvd) return 2;
    if (r >= dvs) return 3;
    return 0;
  endfunction

  // Compare process: every cycle a verdict is shown it must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_valid && out_valid) begin
        check("verdict_pass", {31'd0, pass}, (exp_code == 0) ? 32'd1 : 32'd0);
        check("fail_code", {30'd0, fail_code}, exp_code);
        check("pass_count", {28'd0, pass_count}, m_pass);
        check("fail_count", {28'd0, fail_count}, m_fail);
        check("busy_in_ready", {31'd0, in_ready}, 0);
      end else if (!exp_valid) begin
        check("spurious_out_valid", {31'd0, out_valid}, 0);
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
  endtask

  // Accept one transaction on the next rising edge (edge T).
  task automatic accept(input int dvd, input int dvs, input int q, input int r, input bit err);
    wait_ready();
    dividend = W'(dvd); divisor = W'(dvs); quotient = W'(q); remainder = W'(r);
    div_err = err; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Late input changes must not influence the result.
    dividend = ~dividend; divisor = W'(3); quotient = ~quotient; remainder = ~remainder;
    div_err = ~div_err;
  endtask

  task automatic run_txn(input int dvd, input int dvs, input int q, input int r, input bit err,
                         input int hand_code, input int hold);
    int m, lat;
    m = model_code(dvd, dvs, q, r, err);
    check("model_vs_hand", m, hand_code);
    accept(dvd, dvs, q, r, err);
    exp_code = m;
    if (m == 0) begin
      if (m_pass < CNT_MAX) m_pass++;
    end else begin
      if (m_fail < CNT_MAX) m_fail++;
    end
    exp_valid = 1'b1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, (dvs == 0) ? 2 : W + 2);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = (i == 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_valid = 1'b0;
    check("out_valid_drop", {31'd0, out_valid}, 0);
    check("in_ready_return", {31'd0, in_ready}, 1);
    out_ready = 1'b0;
    if (hold > 0) begin
      @(posedge clk); #1;
      check("pulse_not_accepted", {31'd0, in_ready}, 1);
    end
  endtask

  initial begin
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 1);
    check("idle_counts", {24'd0, pass_count, fail_count}, 0);

    run_txn(100, 7, 14, 2, 1'b0, 0, 0);
    check("hand_pass_count_1", {28'd0, pass_count}, 1);
    run_txn(100, 7, 14, 3, 1'b0, 2, 0);
    check("hand_fail_count_1", {28'd0, fail_count}, 1);
    run_txn(100, 7, 13, 9, 1'b0, 3, 0);
    run_txn(17, 0, 55, 66, 1'b1, 0, 0);
    run_txn(17, 0, 55, 66, 1'b0, 1, 0);
    run_txn(100, 5, 20, 0, 1'b1, 1, 0);
    run_txn(254, 2, 255, 0, 1'b0, 2, 0);
    run_txn(200, 9, 22, 2, 1'b0, 0, 5);
    check("hand_counts_mid", {24'd0, pass_count, fail_count}, {24'd0, 4'd3, 4'd5});

    // Abort during the multiply.
    accept(100, 7, 14, 2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {22'd0, in_ready, out_valid, pass, fail_code, pass_count},
          0);
    check("abort_fail_count", {28'd0, fail_count}, 0);
    m_pass = 0; m_fail = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < (1 << CW) + 2; i++) begin
      int dvs, dvd;
      dvs = i + 1;
      dvd = 250 - i;
      run_txn(dvd, dvs, dvd / dvs, dvd % dvs, 1'b0, 0, 0);
      if (i == 0) check("hand_post_abort_pass", {28'd0, pass_count}, 1);
    end
    check("hand_saturated", {28'd0, pass_count}, 15);
    check("hand_fail_after_sat", {28'd0, fail_count}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
